// File: rtl/yc_config_sequencer_if.sv
// yc_config_sequencer_if: request inputs, vsync and active encoder configuration outputs
interface yc_config_sequencer_if;
  logic        vsync;
  logic        req_pal;
  logic        req_yc_en;
  logic        req_mul_flag;
  logic [4:0]  req_chroma_add;
  logic [4:0]  req_chroma_mul;
  logic [39:0] chroma_phase_inc;
  logic        palflag;
  logic        mulflag;
  logic [4:0]  chromaadd;
  logic [4:0]  chromamul;
  logic        yc_en;
  logic        mute;
  logic        busy;
  logic [7:0]  apply_count;
  modport master (
    output vsync, req_pal, req_yc_en, req_mul_flag, req_chroma_add, req_chroma_mul,
    input  chroma_phase_inc, palflag, mulflag, chromaadd, chromamul, yc_en, mute, busy, apply_count
  );
  modport slave (
    input  vsync, req_pal, req_yc_en, req_mul_flag, req_chroma_add, req_chroma_mul,
    output chroma_phase_inc, palflag, mulflag, chromaadd, chromamul, yc_en, mute, busy, apply_count
  );
endinterface

// File: rtl/yc_config_sequencer.sv
// yc_config_sequencer: debounces requested Y/C settings and applies them atomically on vsync under mute
module yc_config_sequencer #(
  parameter int unsigned SETTLE_FRAMES = 2,
  parameter int unsigned MUTE_FRAMES   = 2,
  parameter logic [39:0] NTSC_INC      = 40'd45812728099,
  parameter logic [39:0] PAL_INC       = 40'd45812728235
) (
  input logic                  clk,
  input logic                  reset_n,
  yc_config_sequencer_if.slave bus
);
  localparam logic [3:0] SF = 4'(SETTLE_FRAMES);
  localparam logic [3:0] MF = 4'(MUTE_FRAMES);
  typedef enum logic [2:0] {IDLE, SETTLE, BLANK_WAIT, APPLY, HOLD} state_t;
  state_t      state_q, state_d;
  logic [12:0] req, active_q, active_d, shadow_q, shadow_d;
  logic [3:0]  scnt_q, scnt_d, mcnt_q, mcnt_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        mute_q, mute_d, vs_q, vs_rise;
  assign req     = {bus.req_pal, bus.req_yc_en, bus.req_mul_flag, bus.req_chroma_add, bus.req_chroma_mul};
  assign vs_rise = bus.vsync & ~vs_q;
  assign {bus.palflag, bus.yc_en, bus.mulflag, bus.chromaadd, bus.chromamul} = active_q;
  assign bus.chroma_phase_inc = active_q[12] ? PAL_INC : NTSC_INC;
  assign bus.mute        = mute_q;
  assign bus.busy        = state_q != IDLE;
  assign bus.apply_count = cnt_q;
  // state, counters, shadow/active copies and vsync delay; reset aborts any sequence in flight
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      active_q <= '0;
      shadow_q <= '0;
      scnt_q   <= '0;
      mcnt_q   <= '0;
      cnt_q    <= '0;
      mute_q   <= 1'b0;
      vs_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      shadow_q <= shadow_d;
      scnt_q   <= scnt_d;
      mcnt_q   <= mcnt_d;
      cnt_q    <= cnt_d;
      mute_q   <= mute_d;
      vs_q     <= bus.vsync;
    end
  end
  // next state: a request change restarts the debounce and beats any same-cycle vsync edge
  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    shadow_d = shadow_q;
    scnt_d   = scnt_q;
    mcnt_d   = mcnt_q;
    cnt_d    = cnt_q;
    mute_d   = mute_q;
    case (state_q)
      IDLE: if (req != active_q) begin
        state_d  = SETTLE;
        shadow_d = req;
        scnt_d   = '0;
      end
      SETTLE: if (req != shadow_q) begin
        shadow_d = req;
        scnt_d   = '0;
      end else if (req == active_q) state_d = IDLE;
      else if (scnt_q == SF) state_d = BLANK_WAIT;
      else if (vs_rise) scnt_d = scnt_q + 4'd1;
      BLANK_WAIT: if (req != shadow_q) begin
        state_d  = SETTLE;
        shadow_d = req;
        scnt_d   = '0;
      end else if (vs_rise) begin
        state_d = APPLY;
        mute_d  = 1'b1;
      end
      APPLY: begin
        state_d  = HOLD;
        active_d = shadow_q;
        cnt_d    = cnt_q + 8'd1;
        mcnt_d   = '0;
      end
      HOLD: if (mcnt_q == MF) begin
        state_d = IDLE;
        mute_d  = 1'b0;
      end else if (vs_rise) mcnt_d = mcnt_q + 4'd1;
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_yc_config_sequencer.sv
// tb_yc_config_sequencer: frame-level reference model with scoreboard for two parameterisations
module tb_yc_config_sequencer;
  localparam logic [39:0] NTSC = 40'd45812728099;
  localparam logic [39:0] PAL  = 40'd45812728235;
  typedef struct {logic [12:0] val; logic [7:0] cnt; int at_edge;} exp_t;
  logic clk = 0, reset_n = 0, vsync = 0;
  logic [12:0] req = '0;
  int cmp = 0, bad = 0, edges = 0;
  int sf[2] = '{2, 0};
  int mf[2] = '{2, 0};
  logic [12:0] m_act[2];
  logic [7:0]  m_cnt[2];
  int m_apl[2];
  int m_chg;
  exp_t sb[2][$];
  logic [12:0] act_w[2];
  logic [39:0] phase_w[2];
  logic [7:0]  cnt_w[2];
  logic        mute_w[2], busy_w[2];
  always #5 clk = ~clk;
  yc_config_sequencer_if ia();
  yc_config_sequencer_if ib();
  assign ia.vsync = vsync;
  assign ib.vsync = vsync;
  assign {ia.req_pal, ia.req_yc_en, ia.req_mul_flag, ia.req_chroma_add, ia.req_chroma_mul} = req;
  assign {ib.req_pal, ib.req_yc_en, ib.req_mul_flag, ib.req_chroma_add, ib.req_chroma_mul} = req;
  assign act_w[0] = {ia.palflag, ia.yc_en, ia.mulflag, ia.chromaadd, ia.chromamul};
  assign act_w[1] = {ib.palflag, ib.yc_en, ib.mulflag, ib.chromaadd, ib.chromamul};
  assign phase_w[0] = ia.chroma_phase_inc;
  assign phase_w[1] = ib.chroma_phase_inc;
  assign cnt_w[0] = ia.apply_count;
  assign cnt_w[1] = ib.apply_count;
  assign mute_w[0] = ia.mute;
  assign mute_w[1] = ib.mute;
  assign busy_w[0] = ia.busy;
  assign busy_w[1] = ib.busy;
  yc_config_sequencer dut_a (.clk(clk), .reset_n(reset_n), .bus(ia));
  yc_config_sequencer #(.SETTLE_FRAMES(0), .MUTE_FRAMES(0)) dut_b (.clk(clk), .reset_n(reset_n), .bus(ib));

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] x);
    cmp++;
    if (a !== x) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", n, a, x);
    end
  endtask

  // A request is applied on the (settle+1)-th vsync edge counted from the later of its last change
  // and the end of the previous mute window, provided it still differs from the active settings.
  task automatic m_reset();
    for (int i = 0; i < 2; i++) begin
      m_act[i] = '0;
      m_cnt[i] = '0;
      m_apl[i] = -100;
      sb[i].delete();
    end
    m_chg = edges;
  endtask

  task automatic set_req(input logic [12:0] v);
    if (v != req) begin
      req   = v;
      m_chg = edges;
    end
  endtask

  task automatic edge_model();
    edges++;
    for (int i = 0; i < 2; i++) begin
      int r;
      r = (m_chg > m_apl[i] + mf[i]) ? m_chg : m_apl[i] + mf[i];
      if (req != m_act[i] && edges == r + sf[i] + 1) begin
        m_act[i] = req;
        m_cnt[i] = m_cnt[i] + 8'd1;
        m_apl[i] = edges;
        sb[i].push_back('{val: req, cnt: m_cnt[i], at_edge: edges});
      end
    end
  endtask

  task automatic frame(input logic [12:0] v);
    repeat (3) @(posedge clk);
    #1 set_req(v);
    repeat (6) @(posedge clk);
    #1 vsync = 1;
    edge_model();
    repeat (3) @(posedge clk);
    #1 vsync = 0;
  endtask

  task automatic chk_reset();
    for (int i = 0; i < 2; i++) begin
      chk("rst_active", act_w[i], 0);
      chk("rst_phase", phase_w[i], NTSC);
      chk("rst_mute", mute_w[i], 0);
      chk("rst_busy", busy_w[i], 0);
      chk("rst_count", cnt_w[i], 0);
    end
  endtask

  // monitor: every apply_count step must match the next expected apply
  initial begin
    logic [7:0] prev_cnt[2];
    logic       prev_mute[2];
    int         apl_edge[2], mute_cyc[2];
    exp_t       e;
    for (int i = 0; i < 2; i++) begin
      prev_cnt[i] = 0; prev_mute[i] = 0; apl_edge[i] = 0; mute_cyc[i] = 0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (!reset_n) begin
          prev_cnt[i] = 0; prev_mute[i] = 0; mute_cyc[i] = 0;
        end else begin
          if (mute_w[i]) mute_cyc[i]++;
          if (cnt_w[i] != prev_cnt[i]) begin
            if (sb[i].size() == 0) begin
              cmp++; bad++;
              $display("FAIL unexpected_apply[%0d]: got count %0d expected no apply", i, cnt_w[i]);
            end else begin
              e = sb[i].pop_front();
              chk("apply_value", act_w[i], e.val);
              chk("apply_phase", phase_w[i], e.val[12] ? PAL : NTSC);
              chk("apply_count", cnt_w[i], e.cnt);
              chk("apply_edge", edges, e.at_edge);
              chk("apply_muted", mute_w[i], 1);
            end
            apl_edge[i] = edges;
            prev_cnt[i] = cnt_w[i];
          end
          if (prev_mute[i] && !mute_w[i]) begin
            chk("mute_frames", edges - apl_edge[i], mf[i]);
            if (i == 1) chk("mute_cycles", mute_cyc[i], 2);
            mute_cyc[i] = 0;
          end
          prev_mute[i] = mute_w[i];
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic [12:0] v, base;
    m_reset();
    req = 13'($urandom);
    repeat (3) @(posedge clk);
    #1 chk_reset();
    req = '0;
    @(posedge clk);
    #1 reset_n = 1;
    m_reset();
    repeat (10) begin
      frame('0);
      chk("idle_busy_a", busy_w[0], 0);
      chk("idle_busy_b", busy_w[1], 0);
    end
    chk("idle_count", cnt_w[0], 0);
    v = {1'b1, 1'b0, 1'b0, 5'd7, 5'd0};
    repeat (6) frame(v);
    chk("basic_pal", ia.palflag, 1);
    chk("basic_add", ia.chromaadd, 7);
    chk("basic_busy", busy_w[0], 0);
    base = v;
    frame({base[12:5], 5'd3});
    frame({base[12:5], 5'd4});
    repeat (6) frame({base[12:5], 5'd5});
    chk("debounce_mul", ia.chromamul, 5);
    base = req;
    frame(base | 13'h800);
    repeat (5) frame(base);
    chk("revert_yc_en", ia.yc_en, base[11]);
    v = base ^ 13'h0021;
    repeat (3) frame(v);
    frame(v | 13'h400);
    repeat (8) frame(v | 13'h400);
    chk("hold_mulflag", ia.mulflag, 1);
    repeat (60) begin
      v = req;
      if ($urandom_range(0, 2) == 0) v = ($urandom_range(0, 1) == 0) ? 13'($urandom) : req ^ (13'd1 << $urandom_range(0, 12));
      frame(v);
    end
    repeat (6) frame(req);
    v = req ^ 13'h1000;
    repeat (3) frame(v);
    chk("hold_mute_before_reset", mute_w[0], 1);
    reset_n = 0;
    #1 chk_reset();
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
    m_reset();
    repeat (6) frame(req);
    reset_n = 0;
    req = '0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
    m_reset();
    for (int k = 0; k < 256; k++) begin
      v = 13'($urandom);
      if (v == m_act[0]) v = v ^ 13'd1;
      repeat (6) frame(v);
    end
    chk("wrap_count", cnt_w[0], 0);
    repeat (2) frame(req);
    chk("sb_drained_a", sb[0].size(), 0);
    chk("sb_drained_b", sb[1].size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule

// File: doc/yc_config_sequencer.md
Name: yc_config_sequencer

Overview:
- Sits between the OSD status bits and the Y/C encoder configuration outputs: chroma phase increment, PAL flag, multiply flag, chroma add, chroma multiply and Y/C enable.
- Takes requested settings and waits until they have been stable for a programmable number of frames.
- Applies them atomically on a VSync rising edge while muting video, so the encoder never sees a mid-frame or partial reconfiguration.
- Holds the mute for a programmable number of frames after the change so the chroma phase accumulator can settle.

Parameters:
- SETTLE_FRAMES, 2: VSync rising edges the request must stay unchanged before it is applied (0..15).
- MUTE_FRAMES, 2: VSync rising edges mute stays asserted after apply (0..15).
- NTSC_INC, 40'd45812728099: phase increment driven when PAL = 0.
- PAL_INC, 40'd45812728235: phase increment driven when PAL = 1.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- vsync  in  1  active-high vertical sync, synchronous to clk.
- req_pal  in  1  requested TV mode (1 = PAL).
- req_yc_en  in  1  requested Y/C enable.
- req_mul_flag  in  1  requested chroma multiply flag.
- req_chroma_add  in  5  requested chroma add timing.
- req_chroma_mul  in  5  requested chroma multiply.
- chroma_phase_inc  out  40  active phase increment.
- palflag  out  1  active PAL flag.
- mulflag  out  1  active multiply flag.
- chromaadd  out  5  active chroma add.
- chromamul  out  5  active chroma multiply.
- yc_en  out  1  active Y/C enable.
- mute  out  1  force video black.
- busy  out  1  high whenever state != IDLE.
- apply_count  out  8  number of applies completed; wraps 255 -> 0.

Behaviour:
- Request vector and active vector: `req = {pal, yc_en, mul_flag, add, mul}` (13 bits). `active` is the registered copy of the same 13 bits that drives the outputs.
- `chroma_phase_inc = palflag ? PAL_INC : NTSC_INC`, decoded from the registered `palflag`. It changes in the same cycle as `palflag`.
- VSync edge: `vs_d` registers `vsync`; `vs_rise = vsync & ~vs_d`. `vs_d` resets to 0.
- Reset (async assert, reset_n = 0):
  - `active` = 0: palflag 0, yc_en 0, mulflag 0, chromaadd 0, chromamul 0, chroma_phase_inc = NTSC_INC.
  - mute 0, busy 0, apply_count 0, state IDLE, counters 0.
  - Reset asserted mid-sequence aborts immediately to these values; no partial apply survives.
- `shadow` (13 bits): the latched copy of `req` that is written into `active` in APPLY.
- States:
  - IDLE: if `req != active`, go to SETTLE with `scnt = 0` and `shadow = req`.
  - SETTLE:
    - If `req != shadow`: `shadow = req`, `scnt = 0`.
    - Else if `req == active`: go to IDLE (request reverted).
    - Else on `vs_rise`: `scnt++`.
    - When `scnt == SETTLE_FRAMES`: go to BLANK_WAIT. With SETTLE_FRAMES = 0 this happens on the cycle after entry.
  - BLANK_WAIT:
    - If `req != shadow`: go to SETTLE, `shadow = req`, `scnt = 0`.
    - Else on `vs_rise`: `mute = 1`, go to APPLY.
  - APPLY (exactly 1 cycle): `active = shadow`, `apply_count++`, `mcnt = 0`, go to HOLD. Outputs show the new values in the cycle after APPLY.
  - HOLD:
    - On `vs_rise`: `mcnt++`.
    - When `mcnt == MUTE_FRAMES`: `mute = 0`, go to IDLE. With MUTE_FRAMES = 0, mute drops on the cycle after APPLY.
    - Request changes during APPLY or HOLD are ignored. They are re-evaluated from IDLE, so at least one IDLE cycle separates two applies.
- Simultaneous events:
  - A `req` change on the same cycle as `vs_rise` in SETTLE or BLANK_WAIT takes the restart path; the edge is not counted.
  - A `vs_rise` on the APPLY cycle is not counted toward `mcnt`.
- Outputs other than `mute` and `apply_count` change only in APPLY.
- `busy` is combinational from state.

Test Plan:
- Reset: hold reset_n = 0 with random req -> all outputs 0, chroma_phase_inc = 45812728099; release with req = 0 -> busy stays 0 for 10 frames, apply_count = 0.
- Basic apply (defaults): set req_pal = 1, chromaadd req = 5'd7, hold -> no change after 1st vs_rise; BLANK_WAIT after 2nd; on 3rd vs_rise mute = 1; next cycle palflag = 1, chromaadd = 7, phase_inc = 45812728235, apply_count = 1; mute drops after 2 further vs_rise; busy then 0.
- Debounce: toggle req_chroma_mul 3 -> 4 -> 5, one step per frame -> no apply until 5 has been stable for 2 vs_rise; exactly one apply; chromamul = 5.
- Revert: change req_yc_en 0 -> 1, then back to 0 before the 2nd vs_rise -> back to IDLE, apply_count unchanged, mute never asserted.
- Change during HOLD: set req_mul_flag = 1 in HOLD -> ignored until IDLE; second full sequence follows; apply_count = 2.
- Corners:
  - SETTLE_FRAMES = 0, MUTE_FRAMES = 0: apply occurs on the 1st vs_rise; mute is high for exactly 2 cycles.
  - Assert reset_n during HOLD: mute = 0 and outputs = reset values immediately.
  - 256 applies: apply_count wraps to 0.
